// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: transmitter FSM states and default 12 MHz timing,
// used by the transmitter, the frame-buffer stage and the bench.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SEND,
    LATCH
  } state_t;

  localparam int PIXEL_BITS       = 24;
  localparam int DEF_NUM_PIXELS   = 64;
  localparam int DEF_BIT_CYCLES   = 15;
  localparam int DEF_T0H_CYCLES   = 4;
  localparam int DEF_T1H_CYCLES   = 8;
  localparam int DEF_LATCH_CYCLES = 720;

endpackage

// File: rtl/ws2812_tx_if.sv
// Pixel stream into the WS2812 transmitter: 24-bit {G,R,B} word with valid/ready.
// Ready is driven by the transmitter from registered state only.
interface ws2812_tx_if;

  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output pixel_data,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  pixel_data,
    input  pixel_valid,
    output pixel_ready
  );

endinterface

// File: rtl/ws2812_bit_gen.sv
// WS2812 bit-cell generator: counts clocks within a bit and drives the high time.
// dout is registered (one clock behind en/bit_val); bit_last flags the final clock of a bit.
module ws2812_bit_gen
  import ws2812_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES = DEF_T1H_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic bit_val,
  output logic bit_last,
  output logic dout
);

  localparam int            CW   = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0H  = CW'(T0H_CYCLES);
  localparam logic [CW-1:0] T1H  = CW'(T1H_CYCLES);

  logic [CW-1:0] cyc;

  assign bit_last = en && (cyc == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc  <= '0;
      dout <= 1'b0;
    end else begin
      dout <= en && (cyc < (bit_val ? T1H : T0H));
      if (!en || bit_last) begin
        cyc <= '0;
      end else begin
        cyc <= cyc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ws2812_tx.sv
// WS2812 frame transmitter: NUM_PIXELS GRB pixels as pulse-width bits, then the latch low time.
// First rising edge 2 clocks after the first pixel transfer; one-pixel hold register, ready only while it is empty.
module ws2812_tx
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS   = DEF_NUM_PIXELS,
  parameter int BIT_CYCLES   = DEF_BIT_CYCLES,
  parameter int T0H_CYCLES   = DEF_T0H_CYCLES,
  parameter int T1H_CYCLES   = DEF_T1H_CYCLES,
  parameter int LATCH_CYCLES = DEF_LATCH_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  ws2812_tx_if.slave  pix,
  output logic        dout,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int            PW    = $clog2(NUM_PIXELS + 1);
  localparam int            LW    = $clog2(LATCH_CYCLES + 1);
  localparam logic [PW-1:0] NPIX  = PW'(NUM_PIXELS);
  localparam logic [LW-1:0] LLAST = LW'(LATCH_CYCLES - 1);
  localparam logic [4:0]    BLAST = 5'(PIXEL_BITS - 1);

  state_t        state;
  logic [23:0]   sr;
  logic [23:0]   hold;
  logic          hold_full;
  logic [PW-1:0] acc_cnt;
  logic [PW-1:0] sent_cnt;
  logic [4:0]    bit_cnt;
  logic [LW-1:0] latch_cnt;
  logic          bit_last;
  logic          xfer;

  assign pix.pixel_ready = busy && !hold_full && (acc_cnt < NPIX) && (state != LATCH);
  assign xfer            = pix.pixel_valid && pix.pixel_ready;

  ws2812_bit_gen #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H_CYCLES (T0H_CYCLES),
    .T1H_CYCLES (T1H_CYCLES)
  ) u_bit_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (state == SEND),
    .bit_val  (sr[23]),
    .bit_last (bit_last),
    .dout     (dout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sr         <= '0;
      hold       <= '0;
      hold_full  <= 1'b0;
      acc_cnt    <= '0;
      sent_cnt   <= '0;
      bit_cnt    <= '0;
      latch_cnt  <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;

      if (xfer) begin
        hold      <= pix.pixel_data;
        hold_full <= 1'b1;
        acc_cnt   <= acc_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= FILL;
            busy     <= 1'b1;
            acc_cnt  <= '0;
            sent_cnt <= '0;
          end
        end

        FILL: begin
          if (hold_full) begin
            sr        <= hold;
            hold_full <= 1'b0;
            bit_cnt   <= '0;
            state     <= SEND;
          end
        end

        SEND: begin
          if (bit_last) begin
            if (bit_cnt == BLAST) begin
              bit_cnt  <= '0;
              sent_cnt <= sent_cnt + 1'b1;
              if ((sent_cnt + 1'b1) == NPIX) begin
                state <= LATCH;
              end else if (hold_full) begin
                // Seamless reload: the next pixel's first bit starts on the following clock.
                sr        <= hold;
                hold_full <= 1'b0;
              end else begin
                underrun <= 1'b1;
                state    <= LATCH;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sr      <= {sr[22:0], 1'b0};
            end
          end
        end

        LATCH: begin
          // A pixel caught in the underrun cycle must not leak into the next frame.
          hold_full <= 1'b0;
          if (latch_cnt == LLAST) begin
            latch_cnt  <= '0;
            frame_done <= 1'b1;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            latch_cnt <= latch_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_tx.sv
// Directed bench for ws2812_tx: instances with 1, 3 and 4 pixels per frame share one clock;
// an expected per-cycle waveform built from the WS2812 bit rules is compared on every falling edge.
module tb_ws2812_tx;
  import ws2812_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start;
  logic        valid;
  logic [23:0] data;
  int          sel;

  logic dout1, busy1, fd1, ur1;
  logic dout3, busy3, fd3, ur3;
  logic dout4, busy4, fd4, ur4;
  logic st1, st3, st4;

  ws2812_tx_if px1 ();
  ws2812_tx_if px3 ();
  ws2812_tx_if px4 ();

  assign px1.pixel_data  = data;
  assign px3.pixel_data  = data;
  assign px4.pixel_data  = data;
  assign px1.pixel_valid = valid && (sel == 1);
  assign px3.pixel_valid = valid && (sel == 3);
  assign px4.pixel_valid = valid && (sel == 4);
  assign st1 = start && (sel == 1);
  assign st3 = start && (sel == 3);
  assign st4 = start && (sel == 4);

  ws2812_tx #(.NUM_PIXELS(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(st1), .pix(px1),
    .dout(dout1), .busy(busy1), .frame_done(fd1), .underrun(ur1)
  );
  ws2812_tx #(.NUM_PIXELS(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(st3), .pix(px3),
    .dout(dout3), .busy(busy3), .frame_done(fd3), .underrun(ur3)
  );
  ws2812_tx #(.NUM_PIXELS(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(st4), .pix(px4),
    .dout(dout4), .busy(busy4), .frame_done(fd4), .underrun(ur4)
  );

  logic m_dout, m_busy, m_fd, m_ur, m_rdy, m_vld;
  assign m_dout = (sel == 1) ? dout1 : (sel == 3) ? dout3 : dout4;
  assign m_busy = (sel == 1) ? busy1 : (sel == 3) ? busy3 : busy4;
  assign m_fd   = (sel == 1) ? fd1   : (sel == 3) ? fd3   : fd4;
  assign m_ur   = (sel == 1) ? ur1   : (sel == 3) ? ur3   : ur4;
  assign m_rdy  = (sel == 1) ? px1.pixel_ready : (sel == 3) ? px3.pixel_ready : px4.pixel_ready;
  assign m_vld  = (sel == 1) ? px1.pixel_valid : (sel == 3) ? px3.pixel_valid : px4.pixel_valid;

  typedef struct packed {
    logic dout;
    logic busy;
    logic fd;
    logic ur;
    logic rdy0;
  } ent_t;

  ent_t        exp_q[$];
  ent_t        ce;
  logic [23:0] pix_arr[4];

  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   t0, fd_at, ur_at, fd_cnt, acc_seen, hi_cnt, rise_cnt, npix_cur;
  logic prev_dout;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  function automatic ent_t mk(input logic d, input logic b, input logic f, input logic u,
                              input logic r);
    return {d, b, f, u, r};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare process: one expected entry per cycle while a frame is being checked.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        ce = exp_q.pop_front();
        chk("dout", int'(m_dout), int'(ce.dout));
        chk("busy", int'(m_busy), int'(ce.busy));
        chk("frame_done", int'(m_fd), int'(ce.fd));
        chk("underrun", int'(m_ur), int'(ce.ur));
        if (ce.rdy0) chk("ready_low", int'(m_rdy), 0);
        if (acc_seen >= npix_cur) chk("ready_after_last_accept", int'(m_rdy), 0);
      end
      if (m_vld && m_rdy) acc_seen++;
      if (m_fd) begin
        fd_cnt++;
        fd_at = cyc - t0;
      end
      if (m_ur) ur_at = cyc - t0;
      if (m_dout) hi_cnt++;
      if (m_dout && !prev_dout) rise_cnt++;
      prev_dout = m_dout;
    end
  end

  // Start a frame, build its expected waveform from the bit rules, drive the source, check totals.
  task automatic run_frame(input int s, input int npix, input int give, input int delay,
                           input int xs1, input int xs2, input int exp_hi, input int exp_len);
    int   sent;
    int   idx;
    int   n_ent;
    logic xfer;
    sel      = s;
    npix_cur = npix;
    sent     = (give < npix) ? give : npix;
    start    = 1'b1;
    tick();
    start     = 1'b0;
    t0        = cyc;
    fd_cnt    = 0;
    acc_seen  = 0;
    hi_cnt    = 0;
    rise_cnt  = 0;
    fd_at     = -1;
    ur_at     = -1;
    prev_dout = 1'b0;

    for (int i = 0; i < delay + 3; i++) exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
    for (int p = 0; p < sent; p++)
      for (int b = 23; b >= 0; b--)
        for (int c = 0; c < DEF_BIT_CYCLES; c++)
          exp_q.push_back(mk(c < (pix_arr[p][b] ? DEF_T1H_CYCLES : DEF_T0H_CYCLES), 1'b1, 1'b0,
                             (give < npix) && (p == sent - 1) && (b == 0) &&
                             (c == DEF_BIT_CYCLES - 1), 1'b0));
    for (int i = 0; i < DEF_LATCH_CYCLES - 1; i++)
      exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1));
    exp_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    for (int i = 0; i < 5; i++) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    n_ent = exp_q.size();
    idx   = 0;
    for (int k = 0; k < n_ent; k++) begin
      valid = (k >= delay) && (idx < give);
      data  = pix_arr[idx];
      start = (k == xs1) || (k == xs2);
      xfer  = valid && m_rdy;
      tick();
      if (xfer) idx++;
    end
    valid = 1'b0;
    start = 1'b0;

    chk("frame_done_count", fd_cnt, 1);
    chk("frame_length", fd_at, exp_len);
    chk("accepted_pixels", acc_seen, give);
    chk("high_clocks", hi_cnt, exp_hi);
    chk("rising_edges", rise_cnt, 24 * sent);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    data  = '0;
    sel   = 1;
    tick();
    tick();
    chk("reset_dout", int'({dout1, dout3, dout4}), 0);
    chk("reset_busy", int'({busy1, busy3, busy4}), 0);
    chk("reset_frame_done", int'({fd1, fd3, fd4}), 0);
    chk("reset_underrun", int'({ur1, ur3, ur4}), 0);
    chk("reset_ready", int'({px1.pixel_ready, px3.pixel_ready, px4.pixel_ready}), 0);
    rst = 1'b0;
    tick();

    // Single pixel: bit 0 and bit 23 are ones, the rest zeros.
    pix_arr[0] = 24'h800001;
    run_frame(1, 1, 1, 0, -1, -1, 104, 1082);

    // Same frame with start pulses during SEND and during LATCH.
    run_frame(1, 1, 1, 0, 100, 700, 104, 1082);

    // FILL stall: pixel offered 50 cycles after start.
    pix_arr[0] = 24'hFFFFFF;
    run_frame(1, 1, 1, 50, -1, -1, 192, 1132);

    // Back-to-back three pixels with an always-valid source.
    pix_arr[0] = 24'hFF0000;
    pix_arr[1] = 24'h00FF00;
    pix_arr[2] = 24'hA5A5A5;
    run_frame(3, 3, 3, 0, -1, -1, 400, 1802);

    // Underrun: four-pixel frame, only the first pixel supplied.
    pix_arr[0] = 24'h0F0F0F;
    run_frame(4, 4, 1, 0, -1, -1, 144, 1082);
    chk("underrun_at", ur_at, 362);
    chk("underrun_to_done", fd_at - ur_at, 720);

    // Reset mid-SEND while the hold register is full.
    sel        = 3;
    npix_cur   = 3;
    pix_arr[0] = 24'hFF0000;
    start      = 1'b1;
    tick();
    start = 1'b0;
    valid = 1'b1;
    data  = pix_arr[0];
    for (int i = 0; i < 93; i++) tick();
    chk("pre_reset_dout", int'(m_dout), 1);
    valid = 1'b0;
    rst   = 1'b1;
    tick();
    chk("mid_reset_dout", int'(m_dout), 0);
    chk("mid_reset_busy", int'(m_busy), 0);
    chk("mid_reset_ready", int'(m_rdy), 0);
    tick();
    rst   = 1'b0;
    start = 1'b1;
    tick();
    start  = 1'b0;
    hi_cnt = 0;
    fd_cnt = 0;
    for (int i = 0; i < 30; i++) tick();
    chk("hold_discarded_dout_high", hi_cnt, 0);
    chk("hold_discarded_busy", int'(m_busy), 1);
    chk("hold_discarded_ready", int'(m_rdy), 1);
    chk("hold_discarded_frame_done", fd_cnt, 0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
